uart_tx_wb: RTL and testbench

- Wishbone B4 pipelined slave (responder) that serialises bytes written by the core's data port onto an 8N1 UART line.
- Sits on a data-bus slave slot, e.g. decoded window 0x1000_8020–0x1000_802F.
- A write FIFO decouples bus writes from the baud-rate shifter.
- Registered ack timing matches the interconnect's registered-strobe return mux.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_wb_fifo.sv | 54 +++++
 rtl/uart_tx_wb.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_wb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: register offsets, STATUS bit
// positions and the transmit FSM state encoding.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVR       = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_wb_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty come from comparing
// the pointer MSBs. A push while full is accepted only if a pop happens in
// the same cycle, so the popped slot is reused.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             pushOk;
    logic             popOk;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem[rptr_q[AW-1:0]];

    assign pushOk = push_i && (!full_o || pop_i);
    assign popOk  = pop_i && !empty_o;
    assign wptr_d = pushOk ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d = popOk  ? rptr_q + 1'b1 : rptr_q;

    // Pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; needs no reset because the pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_wb.sv
// Wishbone B4 pipelined slave that serialises bytes onto an 8N1 UART line.
// Optional TX-empty interrupt and CTRL register enabled by UART_TX_IRQ_EN.
module uart_tx_wb
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h1000_8020,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] RESET_DIV  = 16'd867
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ack_q, ack_d, err_q, err_d, ovr_q, ovr_d;
    logic [31:0]   dat_q, dat_d, rdata;
    logic [15:0]   baudDiv_q, baudDiv_d, cnt_q, cnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d, fifoData;
    tx_state_e     state_q, state_d;
    logic          acc, addrOk, regWr, txWrite, txDrop, fifoPop;
    logic          fifoFull, fifoEmpty, busy;
    logic [1:0]    regOff;
    logic [CW-1:0] fifoCount;
    logic [8:0]    count9;
    logic          unusedBits;

    assign acc        = wb_cyc_i & wb_stb_i;
    assign addrOk     = (wb_adr_i[31:4] == BASE_ADR[31:4]) && (wb_adr_i[1:0] == 2'b00);
    assign regOff     = wb_adr_i[3:2];
    assign regWr      = acc & addrOk & wb_we_i;
    assign txWrite    = regWr & (regOff == REG_TXDATA) & wb_sel_i[0];
    assign txDrop     = txWrite & fifoFull & ~fifoPop;
    assign busy       = (state_q != ST_IDLE);
    assign count9     = 9'(fifoCount);
    assign unusedBits = ^{wb_dat_i[31:16], wb_sel_i[3:2]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (txWrite),
        .data_i  (wb_dat_i[7:0]),
        .pop_i   (fifoPop),
        .data_o  (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

`ifdef UART_TX_IRQ_EN
    logic irqEn_q, irqEn_d, irq_q, irq_d;

    // Interrupt enable register and the registered TX-empty interrupt level.
    always_comb begin
        irqEn_d = irqEn_q;
        if (regWr && (regOff == REG_CTRL) && wb_sel_i[0]) begin
            irqEn_d = wb_dat_i[0];
        end
        irq_d = irqEn_q & fifoEmpty & ~busy & ~txWrite;
    end

    // Interrupt state registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irqEn_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irqEn_q <= irqEn_d;
            irq_q   <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // Register read mux, evaluated in the strobe cycle and returned with ack.
    always_comb begin
        rdata = '0;
        case (regOff)
            REG_STATUS: begin
                rdata[STAT_FULL]  = fifoFull;
                rdata[STAT_EMPTY] = fifoEmpty;
                rdata[STAT_BUSY]  = busy;
                rdata[STAT_OVR]   = ovr_q;
                rdata[STAT_COUNT_LSB +: 8] = count9[7:0];
            end
            REG_BAUDDIV: rdata[15:0] = baudDiv_q;
`ifdef UART_TX_IRQ_EN
            REG_CTRL:    rdata[0] = irqEn_q;
`endif
            default:     rdata = '0;
        endcase
    end

    // Bus response and writable register next-state.
    always_comb begin
        ack_d     = acc & addrOk;
        err_d     = acc & ~addrOk;
        dat_d     = (acc & addrOk & ~wb_we_i) ? rdata : '0;
        baudDiv_d = baudDiv_q;
        ovr_d     = ovr_q;
        if (regWr && (regOff == REG_BAUDDIV)) begin
            if (wb_sel_i[0]) baudDiv_d[7:0]  = wb_dat_i[7:0];
            if (wb_sel_i[1]) baudDiv_d[15:8] = wb_dat_i[15:8];
        end
        if (txDrop) begin
            ovr_d = 1'b1;
        end else if (regWr && (regOff == REG_STATUS) && wb_sel_i[0] && wb_dat_i[STAT_OVR]) begin
            ovr_d = 1'b0;
        end
    end

    // Bus-side registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            baudDiv_q <= RESET_DIV;
            ovr_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            baudDiv_q <= baudDiv_d;
            ovr_q     <= ovr_d;
        end
    end

    // Transmit FSM next-state: each non-idle state lasts BAUDDIV+1 clocks,
    // and the divider is reloaded only at bit boundaries.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        fifoPop  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (!fifoEmpty) begin
                fifoPop = 1'b1;
                shift_d = fifoData;
                cnt_d   = baudDiv_q;
                state_d = ST_START;
            end
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = baudDiv_q;
            case (state_q)
                ST_START: state_d = ST_DATA;
                ST_DATA: begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (!fifoEmpty) begin
                        fifoPop = 1'b1;
                        shift_d = fifoData;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Transmit FSM registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
        end
    end

    // Line level decoded from the registered state so reset forces idle-high at once.
    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            ST_START: tx_o = 1'b0;
            ST_DATA:  tx_o = shift_q[0];
            default:  tx_o = 1'b1;
        endcase
    end

    assign wb_stall_o = 1'b0;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_dat_o   = dat_q;

endmodule

// File: tb/tb_uart_tx_wb.sv
// Directed testbench for uart_tx_wb. Honours UART_TX_IRQ_EN when defined.
`timescale 1ns/1ps
module tb_uart_tx_wb;

    localparam logic [31:0] A_TX   = 32'h1000_8020;
    localparam logic [31:0] A_STAT = 32'h1000_8024;
    localparam logic [31:0] A_BAUD = 32'h1000_8028;
    localparam logic [31:0] A_CTRL = 32'h1000_802C;

    logic        clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, datI = '0;
    logic [3:0]  sel = '0;
    logic        stall, ack, err, txLine, irq;
    logic [31:0] datO;

    int errors = 0;
    int checks = 0;

    uart_tx_wb dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (datI),
        .wb_sel_i   (sel),
        .wb_stall_o (stall),
        .wb_ack_o   (ack),
        .wb_dat_o   (datO),
        .wb_err_o   (err),
        .tx_o       (txLine),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One single-beat access; entered and left at a falling edge.
    task automatic applyStimulus(input logic weIn, input logic [31:0] adrIn, input logic [31:0] datIn,
                                 input logic [3:0] selIn, output logic ackOut, output logic errOut,
                                 output logic [31:0] rdOut);
        cyc = 1'b1; stb = 1'b1; we = weIn; adr = adrIn; datI = datIn; sel = selIn;
        @(negedge clk);
        ackOut = ack; errOut = err; rdOut = datO;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic writeReg(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic k, e;
        logic [31:0] r;
        applyStimulus(1'b1, a, d, s, k, e, r);
        checkOutput({tag, ".ack"}, 32'(k), 32'd1);
    endtask

    task automatic readReg(input string tag, input logic [31:0] a, input logic [31:0] expected);
        logic k, e;
        logic [31:0] r;
        applyStimulus(1'b0, a, 32'h0, 4'hF, k, e, r);
        checkOutput({tag, ".ack"}, 32'(k), 32'd1);
        checkOutput({tag, ".dat"}, r, expected);
    endtask

    // Poll STATUS until empty and idle, then check that state was reached.
    task automatic waitIdle(input string tag, input int maxPolls);
        logic k, e;
        logic [31:0] r = '0;
        for (int n = 0; n < maxPolls; n++) begin
            applyStimulus(1'b0, A_STAT, 32'h0, 4'hF, k, e, r);
            if (r == 32'h2) break;
        end
        checkOutput(tag, r, 32'h2);
    endtask

    task automatic waitTxLow(input int maxCycles);
        for (int n = 0; n < maxCycles && txLine !== 1'b0; n++) @(negedge clk);
    endtask

    initial begin
        logic        k, e;
        logic [31:0] r;
        logic [9:0]  frame;
        int          n;
        logic        irqSeen;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst.tx", 32'(txLine), 32'd1);
        checkOutput("rst.ack", 32'(ack), 32'd0);
        checkOutput("rst.err", 32'(err), 32'd0);
        checkOutput("rst.dat", datO, 32'd0);
        checkOutput("rst.irq", 32'(irq), 32'd0);
        checkOutput("rst.stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // STATUS read: ack exactly one cycle after strobe, one cycle wide
        checkOutput("stat0.preAck", 32'(ack), 32'd0);
        readReg("stat0", A_STAT, 32'h0000_0002);
        checkOutput("stat0.tx", 32'(txLine), 32'd1);
        @(negedge clk);
        checkOutput("stat0.ackDrop", 32'(ack), 32'd0);
        checkOutput("stat0.datDrop", datO, 32'd0);

        // BAUDDIV=3, send 0xA5 and check every clock of the frame
        writeReg("baud3", A_BAUD, 32'h0000_0003, 4'b0011);
        readReg("baud3rd", A_BAUD, 32'h0000_0003);
        readReg("txdRead", A_TX, 32'h0);
        writeReg("txA5", A_TX, 32'h0000_00A5, 4'b0001);
        waitTxLow(20);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            checkOutput($sformatf("a5bit%0d", i), 32'(txLine), 32'(frame[i / 4]));
            @(negedge clk);
        end
        checkOutput("a5idle", 32'(txLine), 32'd1);

        // Busy flag while a frame is on the line
        writeReg("tx3C", A_TX, 32'h0000_003C, 4'b0001);
        repeat (3) @(negedge clk);
        readReg("busy", A_STAT, 32'h0000_0006);
        waitIdle("drainA", 100);

        // BAUDDIV=1 burst of 0xFF bytes. The first byte leaves the FIFO one
        // clock after it is written, so the 18th write is the one that overflows.
        writeReg("baud1", A_BAUD, 32'h0000_0001, 4'b0011);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_TX; datI = 32'hFF; sel = 4'b0001;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            checkOutput($sformatf("burstAck%0d", i), 32'(ack), 32'd1);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        readReg("ovrStat", A_STAT, 32'h0000_100D);
        waitTxLow(100);
        n = 0;
        while (txLine === 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (txLine === 1'b1 && n < 100) begin @(negedge clk); n++; end
        checkOutput("noGap", 32'(n), 32'd20);
        writeReg("ovrClr", A_STAT, 32'h0000_0008, 4'b0001);
        applyStimulus(1'b0, A_STAT, 32'h0, 4'hF, k, e, r);
        checkOutput("ovrCleared", r & 32'h8, 32'h0);
        checkOutput("countMax", 32'(r[15:8] <= 8'd16), 32'd1);
        waitIdle("drainB", 600);

        // Address errors: err instead of ack, no side effects
        applyStimulus(1'b0, 32'h1000_8030, 32'h0, 4'hF, k, e, r);
        checkOutput("err30.err", 32'(e), 32'd1);
        checkOutput("err30.ack", 32'(k), 32'd0);
        checkOutput("err30.dat", r, 32'd0);
        applyStimulus(1'b0, 32'h1000_8022, 32'h0, 4'hF, k, e, r);
        checkOutput("err22.err", 32'(e), 32'd1);
        checkOutput("err22.ack", 32'(k), 32'd0);
        applyStimulus(1'b1, 32'h1000_8022, 32'h55, 4'hF, k, e, r);
        checkOutput("errWrTx.err", 32'(e), 32'd1);
        applyStimulus(1'b1, 32'h1000_8038, 32'hFFFF, 4'b0011, k, e, r);
        checkOutput("errWrBaud.err", 32'(e), 32'd1);
        repeat (2) @(negedge clk);
        readReg("errNoPush", A_STAT, 32'h0000_0002);
        readReg("errNoBaud", A_BAUD, 32'h0000_0001);
        checkOutput("errTx", 32'(txLine), 32'd1);

        // Reset in the middle of a data bit
        writeReg("baud3b", A_BAUD, 32'h0000_0003, 4'b0011);
        writeReg("tx00", A_TX, 32'h0000_0000, 4'b0001);
        writeReg("tx11", A_TX, 32'h0000_0011, 4'b0001);
        waitTxLow(20);
        repeat (6) @(negedge clk);
        checkOutput("preReset.tx", 32'(txLine), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("midReset.tx", 32'(txLine), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        readReg("postRstStat", A_STAT, 32'h0000_0002);
        readReg("postRstBaud", A_BAUD, 32'h0000_0363);

`ifdef UART_TX_IRQ_EN
        // Interrupt: rises one clock after STOP ends, clears on TXDATA write
        writeReg("ctrl1", A_CTRL, 32'h1, 4'b0001);
        readReg("ctrlRd", A_CTRL, 32'h1);
        checkOutput("irqIdle", 32'(irq), 32'd1);
        writeReg("baud1b", A_BAUD, 32'h0000_0001, 4'b0011);
        writeReg("tx5A", A_TX, 32'h0000_005A, 4'b0001);
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i == 1)  checkOutput("irqClear", 32'(irq), 32'd0);
            if (i == 21) checkOutput("irqStop", 32'(irq), 32'd0);
            if (i == 22) checkOutput("irqRise", 32'(irq), 32'd1);
        end
        writeReg("tx5B", A_TX, 32'h0000_005B, 4'b0001);
        @(negedge clk);
        checkOutput("irqClear2", 32'(irq), 32'd0);
        waitIdle("drainC", 100);
`else
        // Without the interrupt option CTRL is read-as-zero and irq never rises
        writeReg("ctrl1", A_CTRL, 32'h1, 4'b0001);
        readReg("ctrlRd", A_CTRL, 32'h0);
        writeReg("baud1b", A_BAUD, 32'h0000_0001, 4'b0011);
        writeReg("tx5A", A_TX, 32'h0000_005A, 4'b0001);
        irqSeen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            irqSeen = irqSeen | irq;
        end
        checkOutput("irqNever", 32'(irqSeen), 32'd0);
        waitIdle("drainC", 100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
